// File: rtl/icache_resp.sv
// icache_resp: direct-mapped 4 KB instruction cache response path with line refill.
// Optional macro ICACHE_PERF_CNT_EN adds the hit_cnt / miss_cnt performance counters.
module icache_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] icache_idx,
    input  logic [2:0]  icache_op,
    input  logic [31:0] icache_pa,
    input  logic        icache_is_cached,
    output logic        icache_ready,
    output logic [31:0] icache_rdata,
    output logic        icache_rvalid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_burst,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam logic [2:0] IC_R       = 3'd1;
    localparam logic [2:0] IC_IDX_INV = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [255:0] r_valid;
    logic [19:0] r_tag  [256];
    logic [31:0] r_data [256][4];
    logic [31:0] r_lbuf [4];
    logic [1:0]  r_beat;
    logic [7:0]  r_set;
    logic [1:0]  r_word;
    logic        r_cached;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_mem_burst;

    logic [7:0]  w_set;
    logic [1:0]  w_word;
    logic        w_is_r;
    logic        w_is_inv;
    logic        w_hit;
    logic        w_ready;
    logic        w_unused;

    assign w_set    = icache_idx[11:4];
    assign w_word   = icache_idx[3:2];
    assign w_is_r   = (icache_op == IC_R);
    assign w_is_inv = (icache_op == IC_IDX_INV);
    assign w_hit    = r_valid[w_set]
                    & (r_tag[w_set] == icache_pa[31:12])
                    & icache_is_cached;
    assign w_unused = ^{icache_idx[1:0], icache_pa[1:0]};

    // Ready: only an IC_R miss stalls in IDLE; DONE answers the held request.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            S_IDLE:  w_ready = !(w_is_r && !w_hit);
            S_DONE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Control FSM: hit response, miss latch, memory handshake, refill commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_beat      <= 2'd0;
            r_set       <= 8'd0;
            r_word      <= 2'd0;
            r_cached    <= 1'b0;
            r_rdata     <= 32'd0;
            r_rvalid    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_burst <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_rvalid <= 1'b0;
                    if (w_is_r && w_hit) begin
                        r_rdata  <= r_data[w_set][w_word];
                        r_rvalid <= 1'b1;
                    end else if (w_is_r) begin
                        r_state     <= S_REQ;
                        r_set       <= w_set;
                        r_word      <= w_word;
                        r_cached    <= icache_is_cached;
                        r_beat      <= 2'd0;
                        r_mem_req   <= 1'b1;
                        r_mem_burst <= icache_is_cached;
                        r_mem_addr  <= icache_is_cached
                                     ? {icache_pa[31:4], 4'h0}
                                     : {icache_pa[31:2], 2'b00};
                    end else if (w_is_inv) begin
                        r_valid[w_set] <= 1'b0;
                    end
                end
                S_REQ: begin
                    r_rvalid <= 1'b0;
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 2'd1;
                        if (mem_rlast) begin
                            r_beat  <= 2'd0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_cached) begin
                        r_valid[r_set] <= 1'b1;
                    end
                    r_rdata  <= r_lbuf[r_cached ? r_word : 2'd0];
                    r_rvalid <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line buffer captures refill beats in arrival order.
    always_ff @(posedge clk) begin
        if (r_state == S_RECV && mem_rvalid) begin
            r_lbuf[r_beat] <= mem_rdata;
        end
    end

    // Tag and data arrays are written only when a cached refill completes.
    always_ff @(posedge clk) begin
        if (r_state == S_DONE && r_cached) begin
            r_tag[r_set] <= r_mem_addr[31:12];
            for (int i = 0; i < 4; i++) begin
                r_data[r_set][i] <= r_lbuf[i];
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Count accepted cached hits and every IDLE to REQ transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if (r_state == S_IDLE && w_is_r) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign icache_ready  = w_ready;
    assign icache_rdata  = r_rdata;
    assign icache_rvalid = r_rvalid;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mem_burst     = r_mem_burst;

endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed plus random fetches against a line-level cache model.
// Counter ports are connected and checked when ICACHE_PERF_CNT_EN is defined.
module tb_icache_resp;

    logic        clk;
    logic        rst_n;
    logic [11:0] icache_idx;
    logic [2:0]  icache_op;
    logic [31:0] icache_pa;
    logic        icache_is_cached;
    logic        icache_ready;
    logic [31:0] icache_rdata;
    logic        icache_rvalid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_burst;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_resp dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_idx       (icache_idx),
        .icache_op        (icache_op),
        .icache_pa        (icache_pa),
        .icache_is_cached (icache_is_cached),
        .icache_ready     (icache_ready),
        .icache_rdata     (icache_rdata),
        .icache_rvalid    (icache_rvalid),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_burst        (mem_burst),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .mem_rlast        (mem_rlast)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: cache contents per set, refill buffer, event counts.
    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_data  [256][4];
    logic [31:0] m_lb    [4];
    logic [31:0] m_fix   [4];
    bit          use_fix;
    int          m_hits;
    int          m_miss;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch-side operation; entered and left at 1 time unit after a rising edge.
    task automatic access(input logic [2:0] op, input logic [11:0] idx,
                          input logic [31:0] pa, input logic c,
                          input int nb, input int gw);
        logic [7:0]  s;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] exp;
        bit          hit;
        s = idx[11:4];
        w = idx[3:2];
        a = c ? {pa[31:4], 4'h0} : {pa[31:2], 2'b00};
        icache_op = op;
        icache_idx = idx;
        icache_pa = pa;
        icache_is_cached = c;
        #1;
        hit = m_valid[s] && (m_tag[s] == pa[31:12]) && c;
        if (op == 3'd1 && !hit) begin
            chk("ready_miss", {31'd0, icache_ready}, 32'd0);
            m_miss++;
            @(posedge clk); #1;
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, a);
            chk("mem_burst", {31'd0, mem_burst}, {31'd0, c});
            icache_op = 3'($urandom_range(0, 7));
            icache_idx = 12'($urandom);
            icache_pa = $urandom;
            icache_is_cached = 1'($urandom);
            for (int k = 0; k < gw; k++) begin
                @(posedge clk); #1;
                chk("req_hold", mem_addr, a);
                chk("req_stall", {31'd0, mem_req, icache_ready}, 32'd2);
            end
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            chk("recv_req", {31'd0, mem_req, icache_ready}, 32'd0);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata = use_fix ? m_fix[i] : $urandom;
                mem_rlast = (i == nb - 1);
                m_lb[i] = mem_rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rlast = 1'b0;
            end
            icache_op = op;
            icache_idx = idx;
            icache_pa = pa;
            icache_is_cached = c;
            #1;
            chk("ready_done", {31'd0, icache_ready}, 32'd1);
            exp = c ? m_lb[w] : m_lb[0];
            if (c) begin
                m_valid[s] = 1'b1;
                m_tag[s] = pa[31:12];
                for (int i = 0; i < 4; i++) m_data[s][i] = m_lb[i];
            end
            @(posedge clk); #1;
            chk("fill_rvalid", {31'd0, icache_rvalid}, 32'd1);
            chk("fill_rdata", icache_rdata, exp);
        end else begin
            chk("ready_idle", {31'd0, icache_ready}, 32'd1);
            @(posedge clk); #1;
            chk("idle_memreq", {31'd0, mem_req}, 32'd0);
            if (op == 3'd1) begin
                m_hits++;
                chk("hit_rvalid", {31'd0, icache_rvalid}, 32'd1);
                chk("hit_rdata", icache_rdata, m_data[s][w]);
            end else begin
                chk("noread_rvalid", {31'd0, icache_rvalid}, 32'd0);
                if (op == 3'd2) m_valid[s] = 1'b0;
            end
        end
        icache_op = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        icache_idx = 12'd0;
        icache_op = 3'd0;
        icache_pa = 32'd0;
        icache_is_cached = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        mem_rlast = 1'b0;
        use_fix = 1'b0;
        m_hits = 0;
        m_miss = 0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 4; i++) m_lb[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'd0, icache_rvalid}, 32'd0);
        chk("rst_rdata", icache_rdata, 32'd0);
        chk("rst_memreq", {30'd0, mem_req, mem_burst}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, icache_ready}, 32'd1);

        // Cold miss then hit in the same line.
        use_fix = 1'b1;
        m_fix[0] = 32'hA0; m_fix[1] = 32'hA1;
        m_fix[2] = 32'hA2; m_fix[3] = 32'hA3;
        access(3'd1, 12'h010, 32'h1C000010, 1'b1, 4, 2);
        chk("cold_rdata", icache_rdata, 32'hA0);
        access(3'd1, 12'h01C, 32'h1C00001C, 1'b1, 4, 0);
        chk("warm_rdata", icache_rdata, 32'hA3);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_miss1", miss_cnt, 32'd1);
        chk("perf_hit1", hit_cnt, 32'd1);
`endif

        // Uncached word access never allocates.
        m_fix[0] = 32'hDEAD;
        access(3'd1, 12'h004, 32'h1FE00004, 1'b0, 1, 1);
        chk("unc_rdata", icache_rdata, 32'hDEAD);
        m_fix[0] = 32'hBEEF;
        access(3'd1, 12'h004, 32'h1FE00004, 1'b0, 1, 0);
        chk("unc_again", icache_rdata, 32'hBEEF);
        use_fix = 1'b0;

        // Invalidate, refill, tag-conflict eviction.
        access(3'd2, 12'h010, 32'h1C000010, 1'b1, 4, 0);
        access(3'd1, 12'h010, 32'h1C000010, 1'b1, 4, 0);
        access(3'd1, 12'h014, 32'h1C001014, 1'b1, 4, 1);
        access(3'd1, 12'h018, 32'h1C000018, 1'b1, 4, 0);

        // Short burst leaves stale buffer words in the line.
        access(3'd1, 12'h020, 32'h1C000020, 1'b1, 2, 0);
        access(3'd1, 12'h02C, 32'h1C00002C, 1'b1, 4, 0);

        // Reset during receive after two beats.
        icache_op = 3'd1;
        icache_idx = 12'h030;
        icache_pa = 32'h1C000030;
        icache_is_cached = 1'b1;
        @(posedge clk); #1;
        chk("abort_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        icache_op = 3'd0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            m_lb[i] = mem_rdata;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_memreq", {31'd0, mem_req}, 32'd0);
        chk("abort_ready", {31'd0, icache_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            mem_rlast = (i == 1);
            @(posedge clk); #1;
            chk("late_beat", {30'd0, mem_req, icache_rvalid}, 32'd0);
        end
        mem_rvalid = 1'b0;
        mem_rlast = 1'b0;
        access(3'd1, 12'h030, 32'h1C000030, 1'b1, 4, 0);
        access(3'd1, 12'h010, 32'h1C000010, 1'b1, 4, 0);

        // Random traffic over a small set/tag pool to mix hits and misses.
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  op;
            logic [11:0] idx;
            logic [31:0] pa;
            logic        c;
            int          r;
            int          nb;
            r = int'($urandom_range(0, 99));
            op = (r < 60) ? 3'd1 : (r < 72) ? 3'd2
               : (r < 86) ? 3'd0 : 3'($urandom_range(3, 7));
            idx = {2'b00, 2'($urandom), 4'($urandom_range(0, 3)), 2'($urandom), 2'b00};
            pa = {19'h0E000, 1'($urandom), idx};
            c = ($urandom_range(0, 9) != 0);
            nb = !c ? 1 : ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 4;
            access(op, idx, pa, c, nb, int'($urandom_range(0, 3)));
        end
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", hit_cnt, 32'(m_hits));
        chk("perf_miss", miss_cnt, 32'(m_miss));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_resp.md
ICACHE_RESP -- requirements
Module: icache_resp

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port icache_idx  in  12  fetch VA bits [11:0]; [11:4] = set index, [3:2] = word in line.
REQ-004 SHALL have port icache_op  in  3  IC_NOP=0, IC_R=1, IC_IDX_INV=2; other codes treated as IC_NOP.
REQ-005 SHALL have port icache_pa  in  32  physical address, same cycle as idx; tag = pa[31:12].
REQ-006 SHALL have port icache_is_cached  in  1  1 = cacheable, 0 = uncached single-word access.
REQ-007 SHALL have port icache_ready  out  1  combinational; request accepted in a cycle with op!=IC_NOP and ready=1.
REQ-008 SHALL have ports icache_rdata  out  32  and icache_rvalid  out  1  instruction word, registered, valid the cycle after an accepted IC_R.
REQ-009 SHALL have memory ports mem_req out 1, mem_addr out 32, mem_burst out 1 (1 = 4-word line, 0 = single word), mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32, mem_rlast in 1.
REQ-010 SHALL expose hit_cnt out 32 and miss_cnt out 32 only when ICACHE_PERF_CNT_EN is defined.

Function
REQ-011 SHALL be direct-mapped, 256 sets x 16-byte lines (4 KB), flop-array storage; per set: valid bit, 20-bit tag, 4 data words.
REQ-012 SHALL compute hit combinationally: valid[idx[11:4]] & tag==pa[31:12] & is_cached.
REQ-013 SHALL implement FSM states IDLE, REQ, RECV, DONE; reset state IDLE.
REQ-014 IDLE: ready=1 for IC_NOP, IC_IDX_INV, or cached hit; ready=0 for IC_R miss or uncached IC_R, FSM -> REQ, request latched (set, word, line-aligned or word-aligned pa, cached flag).
REQ-015 IDLE accepted hit: rdata <= data[set][idx[3:2]], rvalid <= 1 next cycle; else rvalid <= 0.
REQ-016 REQ: mem_req=1 with latched addr (pa & ~0xF if cached, pa & ~0x3 if uncached), mem_burst=cached; hold stable until mem_gnt=1, then -> RECV.
REQ-017 RECV: each mem_rvalid beat stores mem_rdata into 4-entry line buffer at a 2-bit beat counter (reset 0, increments per beat); on beat with mem_rlast -> DONE.
REQ-018 DONE: cached -> write line buffer, tag, valid=1 into latched set; ready=1 for the held request (fetch holds inputs while stalled); rdata = buffer[latched word] (uncached: beat 0), rvalid next cycle; -> IDLE.
REQ-019 Uncached fills SHALL NOT modify tag, valid or data arrays.
REQ-020 Accepted IC_IDX_INV SHALL clear valid[idx[11:4]] next edge; rvalid stays 0.
REQ-021 ready SHALL be 0 in REQ and RECV regardless of op; memory beats arriving outside RECV ignored.
REQ-022 mem_rlast before 4 beats in a burst SHALL still end RECV; unfilled words keep stale buffer contents (protocol error, not detected).
REQ-023 Inputs changing during REQ/RECV SHALL NOT affect the in-flight refill; DONE compares nothing, it answers the latched request.

Reset
REQ-024 On rst_n=0: FSM IDLE, all valid bits 0, beat counter 0, rvalid 0, rdata 0, mem_req 0, mem_addr 0, mem_burst 0, counters 0; tag/data arrays need not reset.
REQ-025 Reset mid-refill SHALL abort immediately; later mem beats ignored until a new REQ is granted.

Configuration
REQ-026 Macro ICACHE_PERF_CNT_EN defined: hit_cnt increments per accepted cached-hit IC_R in IDLE, miss_cnt per IDLE->REQ transition, both wrap at 2^32; undefined: ports and counters absent, behaviour otherwise identical.

Verification
REQ-027 Cold IC_R idx=0x010 pa=0x1C000010 cached -> ready=0, mem_req addr 0x1C000010 burst=1; beats 0xA0..0xA3 -> DONE ready=1, next cycle rdata=0xA0, rvalid=1.
REQ-028 Follow-up IC_R idx=0x01C pa=0x1C00001C -> ready=1 same cycle, rdata=0xA3 next cycle, no mem_req.
REQ-029 Uncached IC_R pa=0x1FE00004 -> mem_addr 0x1FE00004 burst=0, beat 0xDEAD -> rdata=0xDEAD; repeat same pa -> misses again.
REQ-030 IC_IDX_INV idx=0x010 then IC_R pa=0x1C000010 -> miss, refill issued; tag-conflict pa=0x1C001010 also misses and evicts.
REQ-031 rst_n low during RECV after 2 beats -> mem_req=0, IDLE, set still invalid; remaining beats ignored.
REQ-032 With ICACHE_PERF_CNT_EN: REQ-027+REQ-028 sequence -> miss_cnt=1, hit_cnt=1.
